// File: rtl/store_narrow_rmw_if.sv
// Word-memory bus between the store narrowing unit and the data memory.
// The master side issues read/write requests; the slave side is the memory.
interface store_narrow_rmw_if;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_wready;

  modport master (
    output mem_addr,
    output mem_re,
    output mem_we,
    output mem_wdata,
    input  mem_rdata,
    input  mem_rvalid,
    input  mem_wready
  );

  modport slave (
    input  mem_addr,
    input  mem_re,
    input  mem_we,
    input  mem_wdata,
    output mem_rdata,
    output mem_rvalid,
    output mem_wready
  );
endinterface

// File: rtl/store_narrow_rmw.sv
// Store narrowing unit: takes a sb/sh/sw request from the store stage and
// turns it into word-memory traffic. Word stores write straight through;
// byte and halfword stores read the containing word, merge the new lane in
// and write the whole word back. The CPU is held off with busy until the
// done pulse; misaligned or illegal requests and memory timeouts end with
// err alongside done.
module store_narrow_rmw #(
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  store_narrow_rmw_if.master  bus
);

  localparam logic [1:0] OP_WORD = 2'b00;
  localparam logic [1:0] OP_HALF = 2'b01;
  localparam logic [1:0] OP_BYTE = 2'b10;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  // The counter only has to reach TIMEOUT-1, so log2(TIMEOUT) bits suffice.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  logic [2:0]    state;
  logic [1:0]    op_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   merged_q;
  logic [CW-1:0] tmo_cnt;

  logic          req_illegal;
  logic          tmo_last;
  logic [31:0]   merged;

  // Alignment and opcode legality are judged on the live request so that a
  // bad store goes to ERR without ever touching memory.
  assign req_illegal = (op == 2'b11) ||
                       ((op == OP_HALF) && addr[0]) ||
                       ((op == OP_WORD) && (addr[1:0] != 2'b00));

  assign tmo_last = (tmo_cnt == TMO_LAST);

  // Replace the addressed little-endian lane of the fetched word with the
  // narrowed store operand; every other bit keeps the memory contents.
  always_comb begin
    merged = bus.mem_rdata;
    if (op_q == OP_BYTE) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (op_q == OP_HALF) begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end
  end

  // Main control FSM with request latching, merge capture and timeout count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= 2'b00;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      merged_q <= 32'd0;
      tmo_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q    <= op;
            addr_q  <= addr;
            wdata_q <= wdata;
            tmo_cnt <= '0;
            if (req_illegal)          state <= S_ERR;
            else if (op == OP_WORD)   state <= S_WRITE;
            else                      state <= S_READ;
          end
        end
        S_READ: begin
          if (bus.mem_rvalid) begin
            merged_q <= merged;
            tmo_cnt  <= '0;
            state    <= S_WRITE;
          end else if (tmo_last) begin
            state <= S_ERR;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_WRITE: begin
          if (bus.mem_wready) begin
            state <= S_DONE;
          end else if (tmo_last) begin
            state <= S_ERR;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode directly from the state register, so a reset or timeout
  // drops the requests on the very edge that changes state and re/we can
  // never overlap.
  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE) || (state == S_ERR);
  assign err   = (state == S_ERR);

  assign bus.mem_re    = (state == S_READ);
  assign bus.mem_we    = (state == S_WRITE);
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata = (op_q == OP_WORD) ? wdata_q : merged_q;

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Bench for store_narrow_rmw: a small memory model with programmable read
// and write wait states, a table of store requests, and a scoreboard that
// checks every memory write and every completion against expectations
// queued when the request is driven.
module tb_store_narrow_rmw;

  localparam int TIMEOUT = 16;
  localparam int NEVER   = 255;
  localparam int NVEC    = 13;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;

  store_narrow_rmw_if bus();

  store_narrow_rmw #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .addr  (addr),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          rdly;
    int          wdly;
    logic        exp_err;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    int          exp_lat;
    int          exp_re;
    int          exp_we;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  typedef struct {
    logic err;
    int   lat;
    int   re;
    int   we;
    int   start_cyc;
  } cmp_exp_t;

  vec_t     vecs [NVEC];
  wr_exp_t  wr_q [$];
  cmp_exp_t cmp_q [$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int          cur_rdly = 0;
  int          cur_wdly = 0;
  logic [31:0] cur_rdata = 32'd0;
  int          re_wait = 0;
  int          we_wait = 0;
  int          re_cycles = 0;
  int          we_cycles = 0;
  logic        overlap = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model and scoreboard monitor, both evaluated on the falling edge.
  always @(negedge clk) begin
    if (bus.mem_re) begin
      bus.mem_rvalid = (re_wait == cur_rdly);
      re_wait++;
    end else begin
      bus.mem_rvalid = 1'b0;
      re_wait = 0;
    end
    bus.mem_rdata = cur_rdata;
    if (bus.mem_we) begin
      bus.mem_wready = (we_wait == cur_wdly);
      we_wait++;
    end else begin
      bus.mem_wready = 1'b0;
      we_wait = 0;
    end

    if (reset) begin
      re_cycles = 0;
      we_cycles = 0;
      overlap   = 1'b0;
    end else begin
      if (bus.mem_re) re_cycles++;
      if (bus.mem_we) we_cycles++;
      if (bus.mem_re && bus.mem_we) overlap = 1'b1;
      if (bus.mem_we && bus.mem_wready) begin
        if (wr_q.size() == 0) begin
          checkOutput("unexpected_write", 32'd1, 32'd0);
        end else begin
          wr_exp_t w;
          w = wr_q.pop_front();
          checkOutput("mem_addr", bus.mem_addr, w.addr);
          checkOutput("mem_wdata", bus.mem_wdata, w.data);
        end
      end
      if (done) begin
        if (cmp_q.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          cmp_exp_t c;
          c = cmp_q.pop_front();
          checkOutput("err", {31'd0, err}, {31'd0, c.err});
          checkOutput("latency", cyc - c.start_cyc, c.lat);
          checkOutput("re_cycles", re_cycles, c.re);
          checkOutput("we_cycles", we_cycles, c.we);
          checkOutput("re_we_overlap", {31'd0, overlap}, 32'd0);
        end
        re_cycles = 0;
        we_cycles = 0;
        overlap   = 1'b0;
      end
    end
  end

  task automatic waitCompletion();
    for (int i = 0; i < 200 && cmp_q.size() != 0; i++) @(negedge clk);
    if (cmp_q.size() != 0) begin
      checkOutput("completion_timeout", 32'd0, 32'd1);
      cmp_q.delete();
      wr_q.delete();
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    cur_rdly  = v.rdly;
    cur_wdly  = v.wdly;
    cur_rdata = v.rdata;
    if (!v.exp_err) wr_q.push_back('{v.exp_addr, v.exp_wdata});
    cmp_q.push_back('{v.exp_err, v.exp_lat, v.exp_re, v.exp_we, cyc});
    start = 1'b1;
    op    = v.op;
    addr  = v.addr;
    wdata = v.wdata;
    @(negedge clk);
    start = 1'b0;
    waitCompletion();
  endtask

  initial begin
    //            op     addr          wdata         rdata         rdly   wdly   err   exp_addr      exp_wdata     lat re  we
    vecs[0]  = '{2'b00, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 0,     0,     1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 2,  0,  1};
    vecs[1]  = '{2'b10, 32'h0000_0102, 32'h0000_00AA, 32'h1122_3344, 0,     0,     1'b0, 32'h0000_0100, 32'h11AA_3344, 3,  1,  1};
    vecs[2]  = '{2'b01, 32'h0000_0206, 32'h0000_BEEF, 32'h1122_3344, 2,     0,     1'b0, 32'h0000_0204, 32'hBEEF_3344, 5,  3,  1};
    vecs[3]  = '{2'b01, 32'h0000_0101, 32'h0000_1234, 32'h0000_0000, 0,     0,     1'b1, 32'h0000_0000, 32'h0000_0000, 1,  0,  0};
    vecs[4]  = '{2'b00, 32'h0000_0102, 32'h1234_5678, 32'h0000_0000, 0,     0,     1'b1, 32'h0000_0000, 32'h0000_0000, 1,  0,  0};
    vecs[5]  = '{2'b11, 32'h0000_0100, 32'h1234_5678, 32'h0000_0000, 0,     0,     1'b1, 32'h0000_0000, 32'h0000_0000, 1,  0,  0};
    vecs[6]  = '{2'b10, 32'h0000_0103, 32'h1234_5677, 32'hAABB_CCDD, 0,     2,     1'b0, 32'h0000_0100, 32'h77BB_CCDD, 5,  1,  3};
    vecs[7]  = '{2'b10, 32'h0000_0100, 32'h0000_005A, 32'hAABB_CCDD, 0,     0,     1'b0, 32'h0000_0100, 32'hAABB_CC5A, 3,  1,  1};
    vecs[8]  = '{2'b10, 32'h0000_0101, 32'hFFFF_FF01, 32'h0000_0000, 0,     0,     1'b0, 32'h0000_0100, 32'h0000_0100, 3,  1,  1};
    vecs[9]  = '{2'b01, 32'h0000_0200, 32'hFFFF_1234, 32'hCAFE_F00D, 1,     1,     1'b0, 32'h0000_0200, 32'hCAFE_1234, 5,  2,  2};
    vecs[10] = '{2'b10, 32'h0000_0300, 32'h0000_0011, 32'h0000_0000, NEVER, 0,     1'b1, 32'h0000_0000, 32'h0000_0000, 17, 16, 0};
    vecs[11] = '{2'b00, 32'h0000_0304, 32'h0102_0304, 32'h0000_0000, 0,     3,     1'b0, 32'h0000_0304, 32'h0102_0304, 5,  0,  4};
    vecs[12] = '{2'b00, 32'h0000_0308, 32'h0506_0708, 32'h0000_0000, 0,     NEVER, 1'b1, 32'h0000_0000, 32'h0000_0000, 17, 0,  16};

    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    addr  = 32'd0;
    wdata = 32'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_err", {31'd0, err}, 32'd0);
    checkOutput("reset_mem_re", {31'd0, bus.mem_re}, 32'd0);
    checkOutput("reset_mem_we", {31'd0, bus.mem_we}, 32'd0);
    checkOutput("reset_mem_addr", bus.mem_addr, 32'd0);
    checkOutput("reset_mem_wdata", bus.mem_wdata, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      $display("[TB] vector %0d op=%0d addr=0x%08h", i, vecs[i].op, vecs[i].addr);
      applyStimulus(vecs[i]);
    end

    // A second start while busy must be ignored rather than queued.
    $display("[TB] start while busy");
    @(negedge clk);
    cur_rdly  = 3;
    cur_wdly  = 0;
    cur_rdata = 32'h5566_7788;
    wr_q.push_back('{32'h0000_0104, 32'h5566_77EE});
    cmp_q.push_back('{1'b0, 6, 4, 1, cyc});
    start = 1'b1;
    op    = 2'b10;
    addr  = 32'h0000_0104;
    wdata = 32'h0000_00EE;
    @(negedge clk);
    op    = 2'b00;
    addr  = 32'h0000_0500;
    wdata = 32'h9999_9999;
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    repeat (2) @(negedge clk);
    start = 1'b0;
    waitCompletion();
    repeat (6) @(negedge clk);
    checkOutput("idle_after_ignored_start", {31'd0, busy}, 32'd0);

    // Reset while a word write is stalled: requests drop, no write follows.
    $display("[TB] reset during write wait");
    @(negedge clk);
    cur_rdly = 0;
    cur_wdly = NEVER;
    start = 1'b1;
    op    = 2'b00;
    addr  = 32'h0000_0400;
    wdata = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("pre_reset_mem_we", {31'd0, bus.mem_we}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_done", {31'd0, done}, 32'd0);
    checkOutput("midreset_err", {31'd0, err}, 32'd0);
    checkOutput("midreset_mem_re", {31'd0, bus.mem_re}, 32'd0);
    checkOutput("midreset_mem_we", {31'd0, bus.mem_we}, 32'd0);
    checkOutput("midreset_mem_addr", bus.mem_addr, 32'd0);
    checkOutput("midreset_mem_wdata", bus.mem_wdata, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("post_reset_mem_we", {31'd0, bus.mem_we}, 32'd0);
    applyStimulus('{2'b00, 32'h0000_0404, 32'hA5A5_A5A5, 32'h0000_0000, 0, 0,
                    1'b0, 32'h0000_0404, 32'hA5A5_A5A5, 2, 0, 1});

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_writes_drained", wr_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
